frame_return_stack: RTL and testbench
=====================================

FRAME_RETURN_STACK -- requirements
Module: frame_return_stack

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: data-stack TOS pointer width.
REQ-002 SHALL have parameter PC_WIDTH, default 12: return program-counter width.
REQ-003 SHALL have parameter DEPTH, default 16: frame entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1: clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port call_valid  input  1: request to push a frame.
REQ-007 SHALL have port call_ready  output  1: push accepted this cycle if call_valid.
REQ-008 SHALL have port call_tos  input  ADDR_WIDTH: caller's data-stack TOS to save.
REQ-009 SHALL have port call_pc  input  PC_WIDTH: return address to save.
REQ-010 SHALL have port ret_valid  input  1: request to pop a frame.
REQ-011 SHALL have port ret_ready  output  1: pop accepted this cycle if ret_valid.
REQ-012 SHALL have port ret_tos  output  ADDR_WIDTH: registered restored TOS; drives the data-stack TOS mux return input.
REQ-013 SHALL have port ret_pc  output  PC_WIDTH: registered restored return address.
REQ-014 SHALL have port ret_done  output  1: one-cycle pulse, ret_tos/ret_pc updated.
REQ-015 SHALL have port flush  input  1: discard all frames (exception unwind).
REQ-016 SHALL have port err_clr  input  1: clear sticky error flags.
REQ-017 SHALL have ports depth (log2(DEPTH)+1 bits), full, empty, overflow_err, underflow_err, all outputs.

Function
REQ-018 SHALL implement FSM states EMPTY, PARTIAL, FULL; depth 0 = EMPTY, DEPTH = FULL, else PARTIAL.
REQ-019 SHALL drive call_ready = (state != FULL) and ret_ready = (state != EMPTY), combinationally from state only.
REQ-020 SHALL on accepted call alone write {call_tos, call_pc} at index depth and increment depth by 1.
REQ-021 SHALL on accepted ret alone load ret_tos/ret_pc from index depth-1 at the next edge, pulse ret_done that edge, decrement depth.
REQ-022 SHALL hold ret_tos/ret_pc stable between pops; ret_done low otherwise.
REQ-023 SHALL, when call and ret are both accepted (PARTIAL or FULL state with call_ready high), return the current top entry, overwrite that same slot with the new frame, leave depth unchanged.
REQ-024 SHALL in FULL with both valid accept only ret; in EMPTY with both valid accept only call.
REQ-025 SHALL set overflow_err when call_valid and state is FULL and ret not accepted; set underflow_err when ret_valid and state is EMPTY.
REQ-026 SHALL keep error flags sticky until err_clr; a set condition in the same cycle as err_clr wins.
REQ-027 SHALL on flush force depth to 0, state EMPTY, ignore call/ret that cycle, leave ret_tos/ret_pc and error flags unchanged, no ret_done.
REQ-028 SHALL never wrap index: rejected requests cause no storage or depth change.
REQ-029 SHALL assert full/empty as decodes of state, same-cycle with depth.

Reset
REQ-030 SHALL on reset: state EMPTY, depth 0, ret_tos 0, ret_pc 0, ret_done 0, overflow_err 0, underflow_err 0.
REQ-031 SHALL give reset priority over flush, call, ret and err_clr; storage contents need not be cleared.
REQ-032 SHALL discard a request presented in the reset cycle (no pop output after reset release).

Structure
REQ-033 SHALL place the FSM state type and default DEPTH/PC_WIDTH constants in shared package frame_stack_pkg.
REQ-034 SHALL implement storage as sub-module frame_lifo_mem: one synchronous write port, one combinational read port, width ADDR_WIDTH+PC_WIDTH.

Verification
REQ-035 SHALL test: reset, call tos=0x010 pc=0x0A4, then ret -> next edge ret_tos=0x010, ret_pc=0x0A4, ret_done=1 one cycle, depth 0, empty=1.
REQ-036 SHALL test: 16 calls tos=i, 17th call -> full=1, call_ready=0, overflow_err=1, depth 16; 16 rets return tos 15..0 in order.
REQ-037 SHALL test: ret_valid while empty -> ret_ready=0, underflow_err=1, ret_done stays 0; err_clr then clears flag.
REQ-038 SHALL test: depth 3 (top tos=0x022), simultaneous call tos=0x099 and ret -> ret_tos=0x022, depth 3, next ret gives 0x099.
REQ-039 SHALL test: depth 5, flush with call_valid high -> depth 0, empty=1, no write, ret_tos unchanged.
REQ-040 SHALL test: reset asserted mid-sequence at depth 7 with ret_valid -> depth 0, ret_done 0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/frame_stack_pkg.sv
// Shared types and default sizing for the call/return frame stack.
package frame_stack_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_PC_WIDTH   = 12;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } frame_state_t;

endpackage

// File: rtl/frame_lifo_mem.sv
// Frame storage: one synchronous write port, one combinational read port.
module frame_lifo_mem #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/frame_return_stack.sv
// Hardware call/return frame stack: saves {TOS, return PC} on call, restores on ret.
module frame_return_stack
    import frame_stack_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     call_valid,
    output logic                     call_ready,
    input  logic [ADDR_WIDTH-1:0]    call_tos,
    input  logic [PC_WIDTH-1:0]      call_pc,
    input  logic                     ret_valid,
    output logic                     ret_ready,
    output logic [ADDR_WIDTH-1:0]    ret_tos,
    output logic [PC_WIDTH-1:0]      ret_pc,
    output logic                     ret_done,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int DW = IW + 1;
    localparam int EW = ADDR_WIDTH + PC_WIDTH;

    frame_state_t          r_state, w_state_nxt;
    logic [DW-1:0]         r_depth, w_depth_nxt;
    logic [ADDR_WIDTH-1:0] r_ret_tos;
    logic [PC_WIDTH-1:0]   r_ret_pc;
    logic                  r_ret_done, r_ovf, r_unf;
    logic                  w_call_acc, w_ret_acc, w_ovf_set, w_unf_set;
    logic [IW-1:0]         w_top_idx, w_wr_idx;
    logic [EW-1:0]         w_rd_data;

    always_comb begin
        call_ready  = (r_state != FULL);
        ret_ready   = (r_state != EMPTY);
        w_call_acc  = call_valid && call_ready && !flush;
        w_ret_acc   = ret_valid && ret_ready && !flush;
        w_ovf_set   = call_valid && (r_state == FULL) && !w_ret_acc && !flush;
        w_unf_set   = ret_valid && (r_state == EMPTY) && !flush;
        w_depth_nxt = r_depth;
        if (flush)                         w_depth_nxt = '0;
        else if (w_call_acc && !w_ret_acc) w_depth_nxt = r_depth + DW'(1);
        else if (w_ret_acc && !w_call_acc) w_depth_nxt = r_depth - DW'(1);
        w_state_nxt = PARTIAL;
        if (w_depth_nxt == '0)                w_state_nxt = EMPTY;
        else if (w_depth_nxt == DW'(DEPTH))   w_state_nxt = FULL;
    end

    // Index wraps to DEPTH-1 when full; only consulted when a pop is legal.
    assign w_top_idx = r_depth[IW-1:0] - IW'(1);
    // A simultaneous call+ret replaces the popped top slot in place.
    assign w_wr_idx  = w_ret_acc ? w_top_idx : r_depth[IW-1:0];

    frame_lifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_call_acc && !reset),
        .i_waddr (w_wr_idx),
        .i_wdata ({call_tos, call_pc}),
        .i_raddr (w_top_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_depth <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ret_tos  <= '0;
            r_ret_pc   <= '0;
            r_ret_done <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_ret_done <= w_ret_acc;
            if (w_ret_acc) {r_ret_tos, r_ret_pc} <= w_rd_data;
            // Flush freezes the flags, so err_clr is ignored that cycle too.
            if (w_ovf_set)              r_ovf <= 1'b1;
            else if (err_clr && !flush) r_ovf <= 1'b0;
            if (w_unf_set)              r_unf <= 1'b1;
            else if (err_clr && !flush) r_unf <= 1'b0;
        end
    end

    assign ret_tos       = r_ret_tos;
    assign ret_pc        = r_ret_pc;
    assign ret_done      = r_ret_done;
    assign depth         = r_depth;
    assign full          = (r_state == FULL);
    assign empty         = (r_state == EMPTY);
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule

// File: tb/tb_frame_return_stack.sv
// Table vectors, directed corner sequences and random traffic against a queue model.
module tb_frame_return_stack;

    localparam int AW = 12, PW = 12, DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, call_valid, ret_valid, flush, err_clr;
    logic [AW-1:0] call_tos, ret_tos;
    logic [PW-1:0] call_pc, ret_pc;
    logic          call_ready, ret_ready, ret_done, full, empty, overflow_err, underflow_err;
    logic [4:0]    depth;

    always #5 clk = ~clk;

    frame_return_stack #(.ADDR_WIDTH(AW), .PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .call_valid(call_valid), .call_ready(call_ready), .call_tos(call_tos), .call_pc(call_pc),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_tos(ret_tos), .ret_pc(ret_pc),
        .ret_done(ret_done), .flush(flush), .err_clr(err_clr), .depth(depth),
        .full(full), .empty(empty), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain LIFO queue plus the restored registers and flags.
    typedef struct { logic [AW-1:0] tos; logic [PW-1:0] pc; } ent_t;
    ent_t          q[$];
    logic [AW-1:0] m_tos;
    logic [PW-1:0] m_pc;
    logic          m_done, m_ovf, m_unf;
    bit            m_sync = 0;

    task automatic step(input logic rst, input logic cv, input logic [AW-1:0] ct,
                        input logic [PW-1:0] cp, input logic rv, input logic fl, input logic ec);
        bit cacc, racc, novf, nunf;
        ent_t e;
        reset = rst; call_valid = cv; call_tos = ct; call_pc = cp;
        ret_valid = rv; flush = fl; err_clr = ec;
        #1;
        if (m_sync && !rst) begin
            chk("call_ready", call_ready, q.size() != DEPTH);
            chk("ret_ready", ret_ready, q.size() != 0);
        end
        @(posedge clk);
        if (rst) begin
            q.delete(); m_tos = 0; m_pc = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_sync = 1;
        end else if (fl) begin
            q.delete(); m_done = 0;
        end else begin
            cacc = cv && q.size() < DEPTH;
            racc = rv && q.size() > 0;
            novf = cv && q.size() == DEPTH && !racc;
            nunf = rv && q.size() == 0;
            m_done = racc;
            if (racc) begin e = q.pop_back(); m_tos = e.tos; m_pc = e.pc; end
            if (cacc) begin e.tos = ct; e.pc = cp; q.push_back(e); end
            m_ovf = novf ? 1'b1 : (ec ? 1'b0 : m_ovf);
            m_unf = nunf ? 1'b1 : (ec ? 1'b0 : m_unf);
        end
        #1;
        chk("m_depth", 32'(depth), q.size());
        chk("m_ret_tos", ret_tos, m_tos);
        chk("m_ret_pc", ret_pc, m_pc);
        chk("m_ret_done", ret_done, m_done);
        chk("m_full", full, q.size() == DEPTH);
        chk("m_empty", empty, q.size() == 0);
        chk("m_ovf", overflow_err, m_ovf);
        chk("m_unf", underflow_err, m_unf);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic rst, cv; logic [AW-1:0] ct; logic [PW-1:0] cp; logic rv, fl, ec;
        int d; logic [AW-1:0] tos; logic [PW-1:0] pc; logic done, ovf, unf;
    } vec_t;

    function automatic vec_t mk(input logic rst, cv, input logic [AW-1:0] ct, input logic [PW-1:0] cp,
                                input logic rv, fl, ec, input int d, input logic [AW-1:0] tos,
                                input logic [PW-1:0] pc, input logic done, ovf, unf);
        vec_t v;
        v.rst = rst; v.cv = cv; v.ct = ct; v.cp = cp; v.rv = rv; v.fl = fl; v.ec = ec;
        v.d = d; v.tos = tos; v.pc = pc; v.done = done; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        //            rst cv ct     cp     rv fl ec   d  tos    pc     dn ov un
        tbl[0]  = mk(1, 0, 12'h000, 12'h000, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
        tbl[1]  = mk(0, 1, 12'h010, 12'h0A4, 0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0);
        tbl[2]  = mk(0, 0, 12'h000, 12'h000, 1, 0, 0, 0, 12'h010, 12'h0A4, 1, 0, 0);
        tbl[3]  = mk(0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 12'h010, 12'h0A4, 0, 0, 0);
        tbl[4]  = mk(0, 0, 12'h000, 12'h000, 1, 0, 0, 0, 12'h010, 12'h0A4, 0, 0, 1);
        tbl[5]  = mk(0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 12'h010, 12'h0A4, 0, 0, 0);
        tbl[6]  = mk(0, 1, 12'h020, 12'h100, 0, 0, 0, 1, 12'h010, 12'h0A4, 0, 0, 0);
        tbl[7]  = mk(0, 1, 12'h021, 12'h101, 0, 0, 0, 2, 12'h010, 12'h0A4, 0, 0, 0);
        tbl[8]  = mk(0, 1, 12'h022, 12'h102, 0, 0, 0, 3, 12'h010, 12'h0A4, 0, 0, 0);
        tbl[9]  = mk(0, 1, 12'h099, 12'h199, 1, 0, 0, 3, 12'h022, 12'h102, 1, 0, 0);
        tbl[10] = mk(0, 0, 12'h000, 12'h000, 1, 0, 0, 2, 12'h099, 12'h199, 1, 0, 0);
        tbl[11] = mk(0, 1, 12'h030, 12'h130, 0, 0, 0, 3, 12'h099, 12'h199, 0, 0, 0);
        tbl[12] = mk(0, 1, 12'h031, 12'h131, 0, 0, 0, 4, 12'h099, 12'h199, 0, 0, 0);
        tbl[13] = mk(0, 1, 12'h032, 12'h132, 0, 0, 0, 5, 12'h099, 12'h199, 0, 0, 0);
        tbl[14] = mk(0, 1, 12'h0EE, 12'h1EE, 0, 1, 0, 0, 12'h099, 12'h199, 0, 0, 0);
        tbl[15] = mk(0, 0, 12'h000, 12'h000, 1, 0, 0, 0, 12'h099, 12'h199, 0, 0, 1);
        tbl[16] = mk(0, 0, 12'h000, 12'h000, 1, 0, 1, 0, 12'h099, 12'h199, 0, 0, 1);
        tbl[17] = mk(0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 12'h099, 12'h199, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].cv, tbl[i].ct, tbl[i].cp, tbl[i].rv, tbl[i].fl, tbl[i].ec);
            chk($sformatf("tbl%0d_depth", i), 32'(depth), tbl[i].d);
            chk($sformatf("tbl%0d_tos", i), ret_tos, tbl[i].tos);
            chk($sformatf("tbl%0d_pc", i), ret_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_done", i), ret_done, tbl[i].done);
            chk($sformatf("tbl%0d_ovf", i), overflow_err, tbl[i].ovf);
            chk($sformatf("tbl%0d_unf", i), underflow_err, tbl[i].unf);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].d == 0);
        end

        // Fill to capacity, overflow on the 17th call, then drain in LIFO order.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 12'(i), 12'(12'h200 + i), 0, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_depth", 32'(depth), 16);
        call_valid = 1'b1; #1;
        chk("fill_call_ready", call_ready, 0);
        step(0, 1, 12'h0AA, 12'h2AA, 0, 0, 0);
        chk("ovf17_flag", overflow_err, 1);
        chk("ovf17_depth", 32'(depth), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            chk("drain_tos", ret_tos, 32'(15 - i));
            chk("drain_done", ret_done, 1);
        end
        chk("drain_empty", empty, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("ovf_cleared", overflow_err, 0);

        // Reset mid-sequence at depth 7 while a pop is requested.
        for (int i = 0; i < 8; i++) step(0, 1, 12'(12'h300 + i), 12'(12'h400 + i), 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("pre_rst_depth", 32'(depth), 7);
        chk("pre_rst_tos", ret_tos, 12'h307);
        step(1, 0, 0, 0, 1, 0, 0);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_done", ret_done, 0);
        chk("rst_tos", ret_tos, 0);
        chk("rst_pc", ret_pc, 0);
        chk("rst_empty", empty, 1);
        idle();
        chk("post_rst_done", ret_done, 0);
        chk("post_rst_tos", ret_tos, 0);

        // Random traffic; the queue model is checked on every cycle inside step().
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 50),
                 12'($urandom), 12'($urandom), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
